lab3_z1_mac_pipe: RTL and testbench
===================================

// Module: lab3_z1_mac_pipe
// PURPOSE
//  Parametrised pipelined multiply-accumulate for the lab3_z1 datapath. It
//  generalises the fixed 4-stage 16x16 multiplier: configurable operand and
//  accumulator widths, pipeline depth and signedness. Adds a valid pipeline,
//  a multiply/accumulate mode, accumulator clear and a sticky overflow flag.
//  Sits between the operand fetch logic and the result writeback in lab3_z1.
// PARAMETERS
//  A_W        16  width of din0
//  B_W        16  width of din1
//  ACC_W      40  accumulator/dout width; must be >= A_W+B_W
//  NUM_STAGE  4   total latency in ce-qualified cycles; must be >= 3
//  SIGNED     1   1: two's-complement operands/acc; 0: unsigned
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  ce         in   1      clock enable; 0 freezes every register, outputs included
//  in_valid   in   1      din0/din1/clr/mode qualify a sample
//  din0       in   A_W    multiplicand
//  din1       in   B_W    multiplier
//  mode       in   1      0 = multiply only, 1 = accumulate
//  clr        in   1      with mode=1: this sample starts a new sum (acc := product)
//  out_valid  out  1      1-cycle pulse: dout updated by a valid sample
//  dout       out  ACC_W  accumulator / product, held between updates
//  ovf        out  1      sticky overflow of the running accumulation
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert is handled upstream): all
//    pipeline regs, valid bits, dout, out_valid and ovf go to 0.
//  - All registers advance only when ce=1. A sample accepted on edge k
//    (in_valid=1, ce=1) shows out_valid=1 after the NUM_STAGE-th ce edge.
//    Cycles with ce=0 do not count toward latency.
//  - Stage 1: register din0, din1, mode, clr, in_valid.
//  - Stages 2..NUM_STAGE-1: full product P (A_W+B_W bits), signed or unsigned
//    per SIGNED, computed in stage 2 and delayed with its side-band bits.
//  - Stage NUM_STAGE (accumulator register), only when stage valid=1:
//      mode=0          : dout := ext(P); ovf := 0
//      mode=1, clr=1   : dout := ext(P); ovf := 0
//      mode=1, clr=0   : dout := dout + ext(P), wrap-around modulo 2^ACC_W;
//                        ovf := ovf | overflow
//    ext = sign-extend if SIGNED else zero-extend.
//    overflow (SIGNED=1): operand signs equal and result sign differs.
//    overflow (SIGNED=0): carry out of bit ACC_W-1.
//  - Invalid stage (bubble): dout, ovf unchanged; out_valid=0.
//  - out_valid is 0 in any cycle without a valid final-stage update, and it
//    holds its value while ce=0 (frozen with the rest of the pipeline).
//  - Back-to-back valid samples every cycle are supported; no stalls.
//  - clr ignored when mode=0. clr/mode travel with their sample, so mode
//    changes mid-stream take effect per sample in order.
//  - reset mid-operation: all in-flight samples are discarded; no out_valid.
// STRUCTURE
//  - Package lab3_z1_mac_pkg: localparam mode codes (MODE_MUL=0,
//    MODE_ACC=1), function for product width, elaboration checks
//    (ACC_W >= A_W+B_W, NUM_STAGE >= 3).
//  - Sub-module lab3_z1_mac_mult_pipe: stages 1..NUM_STAGE-1 (operand regs,
//    multiply, delay line carrying valid/mode/clr). The top adds the
//    accumulator stage and the overflow logic.
// TESTING
//  1 Reset then NUM_STAGE=4, mode=0: din0=-3, din1=7, valid for one cycle ->
//    out_valid pulses exactly 4 ce-cycles later with dout=-21 (sign-extended
//    to 40 bits); ovf=0.
//  2 mode=1: samples (2,3,clr=1), (4,5), (-1,6) back-to-back -> three
//    consecutive out_valid pulses with dout 6, 26, 20.
//  3 ce toggled 1,0,0,1,... while the 3-sample stream of test 2 is in flight
//    -> same results; latency counts only ce=1 edges; outputs frozen while
//    ce=0.
//  4 ACC_W=32, SIGNED=1, mode=1: clr sample 0x7FFF*0x7FFF, then accumulate
//    the same product 2x more -> dout wraps negative; ovf=1 and stays 1
//    until the next clr or mode=0 sample.
//  5 SIGNED=0, A_W=B_W=8: 255*255 -> dout=65025; interleave in_valid=0
//    bubbles -> no out_valid and dout held during bubbles.
//  6 Assert reset with 3 samples in flight -> outputs 0 immediately
//    (async); no out_valid after deassert until new samples enter.

Source files
------------

// File: rtl/lab3_z1_mac_pkg.sv
// Shared definitions for the lab3_z1 pipelined multiply-accumulate.
// Mode codes, product width helper and configuration sanity check.
package lab3_z1_mac_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // The accumulator must hold a full product and the pipe needs operand,
  // product and accumulator stages at minimum.
  function automatic bit cfg_ok(input int a_w, input int b_w, input int acc_w,
                                input int num_stage);
    return (acc_w >= a_w + b_w) && (num_stage >= 3);
  endfunction

endpackage

// File: rtl/lab3_z1_mac_pipe_if.sv
// Sample/result bus of the lab3_z1 MAC: operand side driven by fetch logic,
// result side consumed by writeback.
interface lab3_z1_mac_pipe_if #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic [A_W-1:0]   din0;
  logic [B_W-1:0]   din1;
  logic             mode;
  logic             clr;
  logic             out_valid;
  logic [ACC_W-1:0] dout;
  logic             ovf;

  modport master (
    output in_valid, din0, din1, mode, clr,
    input  out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din0, din1, mode, clr,
    output out_valid, dout, ovf
  );
endinterface

// File: rtl/lab3_z1_mac_mult_pipe.sv
// Operand register, multiplier and product delay line of the lab3_z1 MAC.
// Covers stages 1..NUM_STAGE-1; valid/mode/clr ride along with each product.
module lab3_z1_mac_mult_pipe
  import lab3_z1_mac_pkg::*;
#(
  parameter int A_W       = 16,
  parameter int B_W       = 16,
  parameter int NUM_STAGE = 4,
  parameter int SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_W-1:0]       din0,
  input  logic [B_W-1:0]       din1,
  input  logic                 mode,
  input  logic                 clr,
  output logic                 vld_o,
  output logic                 mode_o,
  output logic                 clr_o,
  output logic [A_W+B_W-1:0]   prod_o
);

  localparam int P_W = prod_w(A_W, B_W);
  localparam int DLY = NUM_STAGE - 2;

  logic           vld_p1_q, vld_p1_d;
  logic           mode_p1_q, mode_p1_d;
  logic           clr_p1_q, clr_p1_d;
  logic [A_W-1:0] a_p1_q, a_p1_d;
  logic [B_W-1:0] b_p1_q, b_p1_d;

  // Index 0 is stage 2 (fresh product); index DLY-1 feeds the accumulator.
  logic           vld_p2_q  [DLY];
  logic           vld_p2_d  [DLY];
  logic           mode_p2_q [DLY];
  logic           mode_p2_d [DLY];
  logic           clr_p2_q  [DLY];
  logic           clr_p2_d  [DLY];
  logic [P_W-1:0] prod_p2_q [DLY];
  logic [P_W-1:0] prod_p2_d [DLY];

  function automatic logic [P_W-1:0] mul(input logic [A_W-1:0] a,
                                         input logic [B_W-1:0] b);
    logic signed [P_W-1:0] sa;
    logic signed [P_W-1:0] sb;
    logic        [P_W-1:0] ua;
    logic        [P_W-1:0] ub;
    sa = P_W'($signed(a));
    sb = P_W'($signed(b));
    ua = P_W'(a);
    ub = P_W'(b);
    if (SIGNED != 0) return sa * sb;
    return ua * ub;
  endfunction

  always_comb begin
    vld_p1_d  = vld_p1_q;
    mode_p1_d = mode_p1_q;
    clr_p1_d  = clr_p1_q;
    a_p1_d    = a_p1_q;
    b_p1_d    = b_p1_q;
    vld_p2_d  = vld_p2_q;
    mode_p2_d = mode_p2_q;
    clr_p2_d  = clr_p2_q;
    prod_p2_d = prod_p2_q;
    if (ce) begin
      // stage 1: operand capture
      vld_p1_d  = in_valid;
      mode_p1_d = mode;
      clr_p1_d  = clr;
      a_p1_d    = din0;
      b_p1_d    = din1;
      // stage 2: full-width product
      vld_p2_d[0]  = vld_p1_q;
      mode_p2_d[0] = mode_p1_q;
      clr_p2_d[0]  = clr_p1_q;
      prod_p2_d[0] = mul(a_p1_q, b_p1_q);
      // stages 3..NUM_STAGE-1: product delay
      for (int i = 1; i < DLY; i++) begin
        vld_p2_d[i]  = vld_p2_q[i-1];
        mode_p2_d[i] = mode_p2_q[i-1];
        clr_p2_d[i]  = clr_p2_q[i-1];
        prod_p2_d[i] = prod_p2_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      mode_p1_q <= 1'b0;
      clr_p1_q  <= 1'b0;
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      for (int i = 0; i < DLY; i++) begin
        vld_p2_q[i]  <= 1'b0;
        mode_p2_q[i] <= 1'b0;
        clr_p2_q[i]  <= 1'b0;
        prod_p2_q[i] <= '0;
      end
    end else begin
      vld_p1_q  <= vld_p1_d;
      mode_p1_q <= mode_p1_d;
      clr_p1_q  <= clr_p1_d;
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
      vld_p2_q  <= vld_p2_d;
      mode_p2_q <= mode_p2_d;
      clr_p2_q  <= clr_p2_d;
      prod_p2_q <= prod_p2_d;
    end
  end

  assign vld_o  = vld_p2_q[DLY-1];
  assign mode_o = mode_p2_q[DLY-1];
  assign clr_o  = clr_p2_q[DLY-1];
  assign prod_o = prod_p2_q[DLY-1];

endmodule

// File: rtl/lab3_z1_mac_pipe.sv
// Pipelined multiply-accumulate for lab3_z1: multiplier pipe plus the final
// accumulator stage with wrap-around sum and sticky overflow flag.
module lab3_z1_mac_pipe
  import lab3_z1_mac_pkg::*;
#(
  parameter int A_W       = 16,
  parameter int B_W       = 16,
  parameter int ACC_W     = 40,
  parameter int NUM_STAGE = 4,
  parameter int SIGNED    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  lab3_z1_mac_pipe_if.slave  bus
);

  localparam int P_W = prod_w(A_W, B_W);

  if (!cfg_ok(A_W, B_W, ACC_W, NUM_STAGE)) begin : g_cfg_err
    $error("lab3_z1_mac_pipe: need ACC_W >= A_W+B_W and NUM_STAGE >= 3");
  end

  logic             vld_m;
  logic             mode_m;
  logic             clr_m;
  logic [P_W-1:0]   prod_m;

  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] ext_p;
  logic [ACC_W-1:0] sum;

  lab3_z1_mac_mult_pipe #(
    .A_W       (A_W),
    .B_W       (B_W),
    .NUM_STAGE (NUM_STAGE),
    .SIGNED    (SIGNED)
  ) u_mult (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .in_valid (bus.in_valid),
    .din0     (bus.din0),
    .din1     (bus.din1),
    .mode     (bus.mode),
    .clr      (bus.clr),
    .vld_o    (vld_m),
    .mode_o   (mode_m),
    .clr_o    (clr_m),
    .prod_o   (prod_m)
  );

  function automatic logic [ACC_W-1:0] ext_prod(input logic [P_W-1:0] p);
    if (SIGNED != 0) return ACC_W'($signed(p));
    return ACC_W'(p);
  endfunction

  // Signed: like-signed addends giving an opposite-signed result.
  // Unsigned: carry out of the top accumulator bit.
  function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                   input logic [ACC_W-1:0] b);
    logic [ACC_W:0]   wide;
    logic [ACC_W-1:0] s;
    wide = {1'b0, a} + {1'b0, b};
    s    = wide[ACC_W-1:0];
    if (SIGNED != 0)
      return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    return wide[ACC_W];
  endfunction

  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    ext_p       = ext_prod(prod_m);
    sum         = dout_q + ext_p;
    // stage NUM_STAGE: accumulator
    if (ce) begin
      out_valid_d = vld_m;
      if (vld_m) begin
        if (mode_m == MODE_ACC && !clr_m) begin
          dout_d = sum;
          ovf_d  = ovf_q | add_ovf(dout_q, ext_p);
        end else begin
          dout_d = ext_p;
          ovf_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_lab3_z1_mac_pipe.sv
// Bench for lab3_z1_mac_pipe: three configurations driven side by side and
// compared every cycle against an arithmetic reference model.
module tb_lab3_z1_mac_pipe;
  import lab3_z1_mac_pkg::*;

  localparam int AW0 = 16, BW0 = 16, ACC0 = 40, NS0 = 4, SG0 = 1;
  localparam int AW1 = 16, BW1 = 16, ACC1 = 32, NS1 = 5, SG1 = 1;
  localparam int AW2 = 8,  BW2 = 8,  ACC2 = 24, NS2 = 3, SG2 = 0;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  always #5 clk = ~clk;

  lab3_z1_mac_pipe_if #(.A_W(AW0), .B_W(BW0), .ACC_W(ACC0)) ifa ();
  lab3_z1_mac_pipe_if #(.A_W(AW1), .B_W(BW1), .ACC_W(ACC1)) ifb ();
  lab3_z1_mac_pipe_if #(.A_W(AW2), .B_W(BW2), .ACC_W(ACC2)) ifc ();

  lab3_z1_mac_pipe #(.A_W(AW0), .B_W(BW0), .ACC_W(ACC0), .NUM_STAGE(NS0), .SIGNED(SG0))
    u_a (.clk(clk), .reset(reset), .ce(ce), .bus(ifa));
  lab3_z1_mac_pipe #(.A_W(AW1), .B_W(BW1), .ACC_W(ACC1), .NUM_STAGE(NS1), .SIGNED(SG1))
    u_b (.clk(clk), .reset(reset), .ce(ce), .bus(ifb));
  lab3_z1_mac_pipe #(.A_W(AW2), .B_W(BW2), .ACC_W(ACC2), .NUM_STAGE(NS2), .SIGNED(SG2))
    u_c (.clk(clk), .reset(reset), .ce(ce), .bus(ifc));

  logic        iv [3];
  logic        md [3];
  logic        cl [3];
  logic [15:0] d0 [3];
  logic [15:0] d1 [3];

  assign ifa.in_valid = iv[0];
  assign ifa.din0     = d0[0];
  assign ifa.din1     = d1[0];
  assign ifa.mode     = md[0];
  assign ifa.clr      = cl[0];
  assign ifb.in_valid = iv[1];
  assign ifb.din0     = d0[1];
  assign ifb.din1     = d1[1];
  assign ifb.mode     = md[1];
  assign ifb.clr      = cl[1];
  assign ifc.in_valid = iv[2];
  assign ifc.din0     = d0[2][7:0];
  assign ifc.din1     = d1[2][7:0];
  assign ifc.mode     = md[2];
  assign ifc.clr      = cl[2];

  int aw [3];
  int bw [3];
  int accw [3];
  int ns [3];
  bit sg [3];

  typedef struct {
    int     id;
    longint due;
    longint val;
    bit     ovf;
  } exp_t;

  exp_t   q[$];
  longint macc [3];
  bit     movf [3];
  longint cur_val [3];
  bit     cur_ovf [3];
  bit     cur_vld [3];
  longint cecnt;
  int     asserts;
  int     fails;

  function automatic longint interp(input logic [15:0] raw, input int w, input bit s);
    longint v;
    v = longint'(raw) & ((64'sd1 <<< w) - 1);
    if (s && v[w-1]) v = v - (64'sd1 <<< w);
    return v;
  endfunction

  function automatic logic [63:0] mask(input longint v, input int w);
    return 64'(v) & ((64'd1 << w) - 64'd1);
  endfunction

  // Mathematical sum, then wrap into the accumulator range; leaving the
  // range is what counts as overflow.
  function automatic void accept(input int k);
    longint p, s, lim;
    exp_t   e;
    p = interp(d0[k], aw[k], sg[k]) * interp(d1[k], bw[k], sg[k]);
    if (!md[k] || cl[k]) begin
      macc[k] = p;
      movf[k] = 1'b0;
    end else begin
      s = macc[k] + p;
      if (sg[k]) begin
        lim = 64'sd1 <<< (accw[k] - 1);
        if (s >= lim) begin s = s - 2 * lim; movf[k] = 1'b1; end
        else if (s < -lim) begin s = s + 2 * lim; movf[k] = 1'b1; end
      end else begin
        lim = 64'sd1 <<< accw[k];
        if (s >= lim) begin s = s - lim; movf[k] = 1'b1; end
      end
      macc[k] = s;
    end
    e.id  = k;
    e.due = cecnt + longint'(ns[k]) - 1;
    e.val = macc[k];
    e.ovf = movf[k];
    q.push_back(e);
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs,
                     input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 0, 64'(ifa.out_valid), 64'(cur_vld[0]));
    chk("dout",      0, 64'(ifa.dout),      mask(cur_val[0], ACC0));
    chk("ovf",       0, 64'(ifa.ovf),       64'(cur_ovf[0]));
    chk("out_valid", 1, 64'(ifb.out_valid), 64'(cur_vld[1]));
    chk("dout",      1, 64'(ifb.dout),      mask(cur_val[1], ACC1));
    chk("ovf",       1, 64'(ifb.ovf),       64'(cur_ovf[1]));
    chk("out_valid", 2, 64'(ifc.out_valid), 64'(cur_vld[2]));
    chk("dout",      2, 64'(ifc.dout),      mask(cur_val[2], ACC2));
    chk("ovf",       2, 64'(ifc.ovf),       64'(cur_ovf[2]));
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < 3; k++) begin
      macc[k] = 0; movf[k] = 1'b0;
      cur_val[k] = 0; cur_ovf[k] = 1'b0; cur_vld[k] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset && ce) begin
      cecnt++;
      for (int k = 0; k < 3; k++) if (iv[k]) accept(k);
      for (int k = 0; k < 3; k++) cur_vld[k] = 1'b0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == cecnt) begin
          cur_vld[q[i].id] = 1'b1;
          cur_val[q[i].id] = q[i].val;
          cur_ovf[q[i].id] = q[i].ovf;
          q.delete(i);
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input int k, input bit v, input int a, input int b,
                        input bit m, input bit c);
    iv[k] = v; d0[k] = 16'(a); d1[k] = 16'(b); md[k] = m; cl[k] = c;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) set_in(k, 1'b0, 0, 0, MODE_MUL, 1'b0);
  endtask

  initial begin
    int lat;
    int np;
    aw = '{AW0, AW1, AW2};
    bw = '{BW0, BW1, BW2};
    accw = '{ACC0, ACC1, ACC2};
    ns = '{NS0, NS1, NS2};
    sg = '{1'(SG0), 1'(SG1), 1'(SG2)};
    asserts = 0; fails = 0; cecnt = 0;
    ce = 1'b1; reset = 1'b1;
    idle_all();
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // single multiply, latency measured in ce edges
    set_in(0, 1'b1, -3, 7, MODE_MUL, 1'b0);
    set_in(1, 1'b1, -3, 7, MODE_MUL, 1'b0);
    set_in(2, 1'b1, 255, 255, MODE_MUL, 1'b0);
    tick();
    idle_all();
    lat = 1;
    while (ifa.out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    chk("latency", 0, 64'(lat), 64'd4);
    chk("mul_neg", 0, 64'(ifa.dout), 64'h00_0000_00FF_FFFF_FFEB);
    chk("mul_ovf", 0, 64'(ifa.ovf), 64'd0);
    repeat (3) tick();
    chk("u8_mul", 2, 64'(ifc.dout), 64'd65025);

    // back-to-back accumulation
    set_in(0, 1'b1, 2, 3, MODE_ACC, 1'b1); tick();
    set_in(0, 1'b1, 4, 5, MODE_ACC, 1'b0); tick();
    set_in(0, 1'b1, -1, 6, MODE_ACC, 1'b0); tick();
    idle_all();
    np = 0;
    repeat (6) begin tick(); if (ifa.out_valid === 1'b1) np++; end
    chk("acc_pulses", 0, 64'(np), 64'd3);
    chk("acc_sum", 0, 64'(ifa.dout), 64'd20);

    // same stream with ce stalls while in flight
    set_in(0, 1'b1, 2, 3, MODE_ACC, 1'b1); tick();
    set_in(0, 1'b1, 4, 5, MODE_ACC, 1'b0); tick();
    set_in(0, 1'b1, -1, 6, MODE_ACC, 1'b0); tick();
    idle_all();
    for (int i = 0; i < 15; i++) begin ce = (i % 3 == 0); tick(); end
    ce = 1'b1;
    repeat (5) tick();
    chk("ce_sum", 0, 64'(ifa.dout), 64'd20);

    // signed 32-bit accumulator wrap and sticky overflow
    set_in(1, 1'b1, 32'h7FFF, 32'h7FFF, MODE_ACC, 1'b1); tick();
    set_in(1, 1'b1, 32'h7FFF, 32'h7FFF, MODE_ACC, 1'b0); tick();
    tick();
    set_in(1, 1'b1, 1, 1, MODE_ACC, 1'b0); tick();
    idle_all();
    repeat (8) tick();
    chk("wrap_ovf", 1, 64'(ifb.ovf), 64'd1);
    chk("wrap_sign", 1, 64'(ifb.dout[31]), 64'd1);
    set_in(1, 1'b1, 5, 5, MODE_MUL, 1'b1); tick();
    idle_all();
    repeat (6) tick();
    chk("ovf_clear", 1, 64'(ifb.ovf), 64'd0);

    // unsigned: bubbles between samples, then carry-out overflow
    set_in(2, 1'b1, 255, 255, MODE_MUL, 1'b0); tick();
    idle_all(); tick(); tick();
    set_in(2, 1'b1, 17, 3, MODE_ACC, 1'b1); tick();
    idle_all(); tick();
    set_in(2, 1'b1, 255, 255, MODE_ACC, 1'b0); tick();
    idle_all(); repeat (4) tick();
    chk("u8_bubble", 2, 64'(ifc.dout), 64'd65076);
    set_in(2, 1'b1, 255, 255, MODE_ACC, 1'b1); tick();
    set_in(2, 1'b1, 255, 255, MODE_ACC, 1'b0);
    repeat (262) tick();
    idle_all(); repeat (4) tick();
    chk("u_carry", 2, 64'(ifc.ovf), 64'd1);

    // async reset with samples in flight
    for (int k = 0; k < 3; k++) set_in(k, 1'b1, 9 + k, 11, MODE_ACC, 1'b0);
    repeat (2) tick();
    idle_all();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      ce = ($urandom_range(0, 9) < 8);
      for (int k = 0; k < 3; k++)
        set_in(k, $urandom_range(0, 3) != 0, int'($urandom), int'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      tick();
    end
    ce = 1'b1;
    idle_all();
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
